// File: rtl/masked_isw_and_serial_if.sv
// Handshake bundle for the serial ISW masked AND: operand, randomness and
// result channels grouped so the block and its driver share one port.
interface masked_isw_and_serial_if #(
  parameter int NSHARES = 8,
  parameter int WIDTH   = 8
);
  logic                       in_valid;
  logic                       in_ready;
  logic [NSHARES*WIDTH-1:0]   x_shares_i;
  logic [NSHARES*WIDTH-1:0]   y_shares_i;
  logic                       rand_valid;
  logic                       rand_ready;
  logic [WIDTH-1:0]           rand_i;
  logic                       out_valid;
  logic                       out_ready;
  logic [NSHARES*WIDTH-1:0]   z_shares_o;
  logic                       busy_o;

  modport slave (
    input  in_valid, x_shares_i, y_shares_i,
    input  rand_valid, rand_i, out_ready,
    output in_ready, rand_ready, out_valid,
    output z_shares_o, busy_o
  );

  modport master (
    output in_valid, x_shares_i, y_shares_i,
    output rand_valid, rand_i, out_ready,
    input  in_ready, rand_ready, out_valid,
    input  z_shares_o, busy_o
  );
endinterface

// File: rtl/masked_isw_and_serial.sv
// Serialised ISW masked AND: one cross-share pair (i<j) per cycle,
// each pair consuming one fresh random word.
module masked_isw_and_serial #(
  parameter int NSHARES = 8,
  parameter int WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  masked_isw_and_serial_if.slave bus
);
  localparam int CW = (NSHARES > 2) ? $clog2(NSHARES) : 1;
  localparam logic [CW-1:0] LAST_I = CW'(NSHARES - 2);
  localparam logic [CW-1:0] LAST_J = CW'(NSHARES - 1);

  typedef enum logic [1:0] {
    IDLE,
    CROSS,
    DONE
  } state_e;

  state_e state_q;

  logic [NSHARES-1:0][WIDTH-1:0] x_q;
  logic [NSHARES-1:0][WIDTH-1:0] y_q;
  logic [NSHARES-1:0][WIDTH-1:0] z_q;
  logic [NSHARES-1:0][WIDTH-1:0] z_d;

  logic [CW-1:0] i_q, j_q;
  logic [CW-1:0] i_d, j_d;
  logic          last_pair;

  logic in_ready_q;
  logic rand_ready_q;
  logic out_valid_q;
  logic busy_q;

  // i != j always, so the two share updates never collide
  always_comb begin
    z_d = z_q;
    z_d[i_q] = z_q[i_q] ^ bus.rand_i;
    z_d[j_q] = z_q[j_q]
             ^ ((bus.rand_i ^ (x_q[i_q] & y_q[j_q]))
             ^ (x_q[j_q] & y_q[i_q]));
  end

  always_comb begin
    last_pair = (i_q == LAST_I) && (j_q == LAST_J);
    i_d = i_q;
    j_d = j_q + CW'(1);
    if (j_q == LAST_J) begin
      i_d = i_q + CW'(1);
      j_d = i_q + CW'(2);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      i_q          <= '0;
      j_q          <= CW'(1);
      x_q          <= '0;
      y_q          <= '0;
      z_q          <= '0;
      in_ready_q   <= 1'b1;
      rand_ready_q <= 1'b0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            x_q          <= bus.x_shares_i;
            y_q          <= bus.y_shares_i;
            z_q          <= bus.x_shares_i & bus.y_shares_i;
            i_q          <= '0;
            j_q          <= CW'(1);
            state_q      <= CROSS;
            in_ready_q   <= 1'b0;
            rand_ready_q <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        CROSS: begin
          if (bus.rand_valid) begin
            z_q <= z_d;
            if (last_pair) begin
              state_q      <= DONE;
              rand_ready_q <= 1'b0;
              out_valid_q  <= 1'b1;
            end else begin
              i_q <= i_d;
              j_q <= j_d;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.rand_ready = rand_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.busy_o     = busy_q;
  assign bus.z_shares_o = z_q;
endmodule

// File: tb/tb_masked_isw_and_serial.sv
// Directed bench for the serial ISW masked AND: N=8/W=8 instance for
// latency, stall, backpressure and abort; N=2/W=1 instance exhaustively.
module tb_masked_isw_and_serial;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  masked_isw_and_serial_if #(.NSHARES(8), .WIDTH(8)) bus ();
  masked_isw_and_serial_if #(.NSHARES(2), .WIDTH(1)) bus2 ();

  masked_isw_and_serial #(.NSHARES(8), .WIDTH(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  masked_isw_and_serial #(.NSHARES(2), .WIDTH(1)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [7:0] xor8(input logic [63:0] v);
    logic [7:0] a = '0;
    for (int k = 0; k < 8; k++) a ^= v[k*8 +: 8];
    return a;
  endfunction

  function automatic logic [63:0] share8(input logic [7:0] v);
    logic [63:0] s;
    logic [7:0]  a = v;
    for (int k = 1; k < 8; k++) begin
      s[k*8 +: 8] = 8'($urandom);
      a ^= s[k*8 +: 8];
    end
    s[7:0] = a;
    return s;
  endfunction

  task automatic accept8(input logic [63:0] xs, input logic [63:0] ys);
    @(negedge clk);
    bus.x_shares_i = xs;
    bus.y_shares_i = ys;
    bus.in_valid   = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid   = 1'b0;
    bus.x_shares_i = {$urandom, $urandom};
    bus.y_shares_i = {$urandom, $urandom};
  endtask

  task automatic test_reset;
    bus.in_valid = 0; bus.rand_valid = 0; bus.rand_i = '0;
    bus.out_ready = 1; bus.x_shares_i = '0; bus.y_shares_i = '0;
    bus2.in_valid = 0; bus2.rand_valid = 0; bus2.rand_i = '0;
    bus2.out_ready = 1; bus2.x_shares_i = '0; bus2.y_shares_i = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    n_tests++;
    if ({bus.in_ready, bus.out_valid, bus.rand_ready, bus.busy_o}
        !== 4'b1000 || bus.z_shares_o !== 64'h0) begin
      n_fail++;
      $display("FAIL reset8 rdy/ov/rr/busy=%b%b%b%b z=%h exp 1000 z=0",
               bus.in_ready, bus.out_valid, bus.rand_ready,
               bus.busy_o, bus.z_shares_o);
    end
    n_tests++;
    if ({bus2.in_ready, bus2.out_valid, bus2.busy_o} !== 3'b100 ||
        bus2.z_shares_o !== 2'b00) begin
      n_fail++;
      $display("FAIL reset2 rdy/ov/busy=%b%b%b z=%b exp 100 z=00",
               bus2.in_ready, bus2.out_valid, bus2.busy_o,
               bus2.z_shares_o);
    end
  endtask

  task automatic test_random_masks;
    int lat = 0;
    accept8(share8(8'hF0), share8(8'h3C));
    bus.rand_valid = 1'b1;
    bus.rand_i = 8'($urandom);
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      bus.rand_i = 8'($urandom);
    end
    n_tests++;
    if (lat !== 28) begin
      n_fail++;
      $display("FAIL lat_rand got=%0d exp=28", lat);
    end
    n_tests++;
    if (xor8(bus.z_shares_o) !== 8'h30) begin
      n_fail++;
      $display("FAIL xor_rand got=%h exp=30", xor8(bus.z_shares_o));
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_ret rdy=%b ov=%b exp rdy=1 ov=0",
               bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_zero_rand;
    int lat = 0;
    logic [63:0] xs, ys;
    logic [7:0]  xa[8], ya[8], exp_z;
    xs = share8(8'hF0);
    ys = share8(8'h3C);
    for (int k = 0; k < 8; k++) begin
      xa[k] = xs[k*8 +: 8];
      ya[k] = ys[k*8 +: 8];
    end
    bus.rand_i = '0;
    accept8(xs, ys);
    bus.rand_i = '0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    n_tests++;
    if (lat !== 28 || xor8(bus.z_shares_o) !== 8'h30) begin
      n_fail++;
      $display("FAIL zero_rand lat=%0d xor=%h exp lat=28 xor=30",
               lat, xor8(bus.z_shares_o));
    end
    for (int k = 0; k < 8; k++) begin
      exp_z = xa[k] & ya[k];
      for (int i = 0; i < k; i++)
        exp_z ^= (xa[i] & ya[k]) ^ (xa[k] & ya[i]);
      n_tests++;
      if (bus.z_shares_o[k*8 +: 8] !== exp_z) begin
        n_fail++;
        $display("FAIL share%0d got=%h exp=%h", k,
                 bus.z_shares_o[k*8 +: 8], exp_z);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_stall;
    int lat = 0;
    int bad = 0;
    accept8(share8(8'hF0), share8(8'h3C));
    bus.rand_valid = 1'b1;
    while (!bus.out_valid && lat < 100) begin
      if (bus.rand_ready !== 1'b1) bad++;
      @(posedge clk);
      #1;
      lat++;
      bus.rand_i = 8'($urandom);
      if (lat == 10) bus.rand_valid = 1'b0;
      if (lat == 15) bus.rand_valid = 1'b1;
    end
    n_tests++;
    if (lat !== 33) begin
      n_fail++;
      $display("FAIL lat_stall got=%0d exp=33", lat);
    end
    n_tests++;
    if (xor8(bus.z_shares_o) !== 8'h30) begin
      n_fail++;
      $display("FAIL xor_stall got=%h exp=30", xor8(bus.z_shares_o));
    end
    n_tests++;
    if (bad !== 0 || bus.rand_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_cross low_cycles=%0d rr_done=%b exp 0,0",
               bad, bus.rand_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure;
    int lat = 0;
    logic [63:0] snap;
    bus.out_ready = 1'b0;
    accept8(share8(8'h5A), share8(8'hC3));
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    n_tests++;
    if (lat !== 28 || xor8(bus.z_shares_o) !== 8'h42) begin
      n_fail++;
      $display("FAIL bp_first lat=%0d xor=%h exp lat=28 xor=42",
               lat, xor8(bus.z_shares_o));
    end
    snap = bus.z_shares_o;
    repeat (10) begin
      @(posedge clk);
      #1;
      n_tests++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
          bus.z_shares_o !== snap) begin
        n_fail++;
        $display("FAIL bp_hold ov=%b rdy=%b z=%h exp ov=1 rdy=0 z=%h",
                 bus.out_valid, bus.in_ready, bus.z_shares_o, snap);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release rdy=%b ov=%b exp rdy=1 ov=0",
               bus.in_ready, bus.out_valid);
    end
    bus.x_shares_i = share8(8'hAA);
    bus.y_shares_i = share8(8'h0F);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.x_shares_i = '1;
    bus.y_shares_i = '1;
    n_tests++;
    if (bus.busy_o !== 1'b1 || bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_reaccept busy=%b rdy=%b exp busy=1 rdy=0",
               bus.busy_o, bus.in_ready);
    end
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    n_tests++;
    if (lat !== 28 || xor8(bus.z_shares_o) !== 8'h0A) begin
      n_fail++;
      $display("FAIL bp_second lat=%0d xor=%h exp lat=28 xor=0a",
               lat, xor8(bus.z_shares_o));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_abort;
    int lat = 0;
    int early = 0;
    accept8(share8(8'hF0), share8(8'h3C));
    while (lat < 15) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.out_valid) early++;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n_tests++;
    if (early !== 0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
        bus.busy_o !== 1'b0 || bus.rand_ready !== 1'b0 ||
        bus.z_shares_o !== 64'h0) begin
      n_fail++;
      $display("FAIL abort rdy=%b ov=%b busy=%b rr=%b z=%h early=%0d exp 1,0,0,0,0,0",
               bus.in_ready, bus.out_valid, bus.busy_o,
               bus.rand_ready, bus.z_shares_o, early);
    end
    accept8(share8(8'hFF), share8(8'hA5));
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      bus.rand_i = 8'($urandom);
    end
    n_tests++;
    if (lat !== 28 || xor8(bus.z_shares_o) !== 8'hA5) begin
      n_fail++;
      $display("FAIL after_abort lat=%0d xor=%h exp lat=28 xor=a5",
               lat, xor8(bus.z_shares_o));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_n2_exhaustive;
    logic [4:0] c;
    logic       exp_z;
    for (int n = 0; n < 32; n++) begin
      c = 5'(n);
      @(negedge clk);
      bus2.x_shares_i = c[1:0];
      bus2.y_shares_i = c[3:2];
      bus2.rand_i     = c[4];
      bus2.rand_valid = 1'b1;
      bus2.in_valid   = 1'b1;
      @(posedge clk);
      #1;
      bus2.in_valid   = 1'b0;
      bus2.x_shares_i = ~c[1:0];
      bus2.y_shares_i = ~c[3:2];
      @(posedge clk);
      #1;
      exp_z = (c[0] ^ c[1]) & (c[2] ^ c[3]);
      n_tests++;
      if (bus2.out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL n2_lat combo=%0d ov=%b exp=1", n, bus2.out_valid);
      end
      n_tests++;
      if ((bus2.z_shares_o[0] ^ bus2.z_shares_o[1]) !== exp_z) begin
        n_fail++;
        $display("FAIL n2_xor combo=%0d z=%b exp_xor=%b",
                 n, bus2.z_shares_o, exp_z);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_random_masks();
    test_zero_rand();
    test_stall();
    test_backpressure();
    test_abort();
    test_n2_exhaustive();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
